// File: rtl/voice_read_scheduler_if.sv
// Playback request / read-return bundle between the voice scheduler and the RAM arbiter.
// master = scheduler side, slave = arbiter side.
interface voice_read_scheduler_if #(
  parameter int ID_W   = 3,
  parameter int ADDR_W = 27,
  parameter int DATA_W = 16
);
  logic              playback_req;
  logic [ADDR_W-1:0] playback_addr;
  logic [ID_W-1:0]   r_id_out;
  logic              req_ready;
  logic              data_ready;
  logic [DATA_W-1:0] from_ram;
  logic [ID_W-1:0]   r_id_in;

  modport master (
    output playback_req, playback_addr, r_id_out,
    input  req_ready, data_ready, from_ram, r_id_in
  );

  modport slave (
    input  playback_req, playback_addr, r_id_out,
    output req_ready, data_ready, from_ram, r_id_in
  );
endinterface

// File: rtl/voice_read_scheduler.sv
// Per-tick walk over active voices issuing one tagged RAM read each; returns routed by id.
// Request strobe is decoded from registered state the cycle after the tick; a low req_ready holds the walk.
module voice_read_scheduler #(
  parameter int NUM_VOICES = 8,
  parameter int ID_W       = 3,
  parameter int ADDR_W     = 27,
  parameter int DATA_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_tick,
  input  logic [NUM_VOICES-1:0]        voice_start,
  input  logic [NUM_VOICES-1:0]        voice_stop,
  input  logic [NUM_VOICES-1:0]        loop_en,
  input  logic [NUM_VOICES*ADDR_W-1:0] start_addr_v,
  input  logic [NUM_VOICES*ADDR_W-1:0] end_addr_v,
  voice_read_scheduler_if.master       bus,
  output logic [NUM_VOICES*DATA_W-1:0] voice_sample,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic                         frame_done,
  output logic                         overrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_RESP} state_t;

  state_t                  state_q, state_d;
  logic [ID_W-1:0]         idx_q, idx_d;
  logic [NUM_VOICES-1:0]   active_q, active_d;
  logic [NUM_VOICES-1:0]   outstanding_q, outstanding_d;
  logic [NUM_VOICES-1:0]   start_pend_q, start_pend_d;
  logic [NUM_VOICES-1:0]   stop_pend_q, stop_pend_d;
  logic [ADDR_W-1:0]       cur_addr_q [NUM_VOICES];
  logic [ADDR_W-1:0]       cur_addr_d [NUM_VOICES];
  logic [DATA_W-1:0]       sample_q [NUM_VOICES];
  logic [DATA_W-1:0]       sample_d [NUM_VOICES];
  logic                    overrun_q, overrun_d;

  logic                    sel_active, sel_loop;
  logic [ADDR_W-1:0]       sel_cur, sel_start, sel_end;
  logic                    req_c, frame_done_c;
  logic [ADDR_W-1:0]       addr_c;
  logic [ID_W-1:0]         rid_c;

  always_comb begin
    sel_active = 1'b0;
    sel_loop   = 1'b0;
    sel_cur    = '0;
    sel_start  = '0;
    sel_end    = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (idx_q == ID_W'(v)) begin
        sel_active = active_q[v];
        sel_loop   = loop_en[v];
        sel_cur    = cur_addr_q[v];
        sel_start  = start_addr_v[v*ADDR_W +: ADDR_W];
        sel_end    = end_addr_v[v*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    active_d      = active_q;
    outstanding_d = outstanding_q;
    start_pend_d  = start_pend_q | voice_start;
    stop_pend_d   = stop_pend_q | voice_stop;
    overrun_d     = overrun_q | (sample_tick && (state_q != ST_IDLE));
    cur_addr_d    = cur_addr_q;
    sample_d      = sample_q;
    req_c         = 1'b0;
    addr_c        = '0;
    rid_c         = '0;
    frame_done_c  = 1'b0;

    // Returns are accepted in every state; unexpected ids are dropped.
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (bus.data_ready && (bus.r_id_in == ID_W'(v)) && outstanding_q[v]) begin
        sample_d[v]      = bus.from_ram;
        outstanding_d[v] = 1'b0;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (sample_tick) begin
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (stop_pend_d[v]) begin
              active_d[v] = 1'b0;
            end else if (start_pend_d[v]) begin
              active_d[v]   = 1'b1;
              cur_addr_d[v] = start_addr_v[v*ADDR_W +: ADDR_W];
            end
          end
          start_pend_d = '0;
          stop_pend_d  = '0;
          idx_d        = '0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!(sel_active && !bus.req_ready)) begin
          if (sel_active) begin
            req_c  = 1'b1;
            addr_c = sel_cur;
            rid_c  = idx_q;
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (idx_q == ID_W'(v)) begin
                outstanding_d[v] = 1'b1;
                if (sel_cur != sel_end) begin
                  cur_addr_d[v] = sel_cur + ADDR_W'(1);
                end else if (sel_loop) begin
                  cur_addr_d[v] = sel_start;
                end else begin
                  active_d[v] = 1'b0;
                end
              end
            end
          end
          if (idx_q == ID_W'(NUM_VOICES-1)) begin
            state_d = ST_WAIT_RESP;
          end else begin
            idx_d = idx_q + ID_W'(1);
          end
        end
      end
      ST_WAIT_RESP: begin
        if (outstanding_q == '0) begin
          frame_done_c = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      active_q      <= '0;
      outstanding_q <= '0;
      start_pend_q  <= '0;
      stop_pend_q   <= '0;
      overrun_q     <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        cur_addr_q[v] <= '0;
        sample_q[v]   <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      active_q      <= active_d;
      outstanding_q <= outstanding_d;
      start_pend_q  <= start_pend_d;
      stop_pend_q   <= stop_pend_d;
      overrun_q     <= overrun_d;
      cur_addr_q    <= cur_addr_d;
      sample_q      <= sample_d;
    end
  end

  always_comb begin
    voice_sample = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_sample[v*DATA_W +: DATA_W] = sample_q[v];
    end
  end

  assign bus.playback_req  = req_c;
  assign bus.playback_addr = addr_c;
  assign bus.r_id_out      = rid_c;
  assign voice_active      = active_q;
  assign frame_done        = frame_done_c;
  assign overrun           = overrun_q;

endmodule

// File: tb/tb_voice_read_scheduler.sv
// Directed bench for voice_read_scheduler: the bench plays the RAM arbiter and checks
// request order/timing, sample routing, frame_done, overrun and reset against hand-computed values.
`timescale 1ns/1ps
module tb_voice_read_scheduler;
  localparam int NV = 8;
  localparam int IDW = 3;
  localparam int AW = 27;
  localparam int DW = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             sample_tick = 1'b0;
  logic [NV-1:0]    voice_start = '0;
  logic [NV-1:0]    voice_stop = '0;
  logic [NV-1:0]    loop_en = '0;
  logic [NV*AW-1:0] start_addr_v = '0;
  logic [NV*AW-1:0] end_addr_v = '0;
  logic [NV*DW-1:0] voice_sample;
  logic [NV-1:0]    voice_active;
  logic             frame_done;
  logic             overrun;

  int total = 0;
  int bad = 0;

  int             n_req, fd_cnt, fd_cyc;
  logic [AW-1:0]  r_addr [16];
  logic [IDW-1:0] r_id [16];
  int             r_cyc [16];

  voice_read_scheduler_if #(.ID_W(IDW), .ADDR_W(AW), .DATA_W(DW)) bus ();

  voice_read_scheduler #(.NUM_VOICES(NV), .ID_W(IDW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .voice_start(voice_start), .voice_stop(voice_stop), .loop_en(loop_en),
    .start_addr_v(start_addr_v), .end_addr_v(end_addr_v), .bus(bus),
    .voice_sample(voice_sample), .voice_active(voice_active),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_voice(input int v, input logic [AW-1:0] s, input logic [AW-1:0] e);
    start_addr_v[v*AW +: AW] = s;
    end_addr_v[v*AW +: AW]   = e;
  endtask

  // Tick at frame cycle 0, then act as arbiter: record requests, optionally return each one next cycle.
  task automatic do_frame(input bit hold_ret, input int max_k, input int stall_lo, input int stall_hi);
    bit             pend, done_f;
    logic [IDW-1:0] pid;
    logic [DW-1:0]  pdat;
    n_req = 0; fd_cnt = 0; fd_cyc = -1;
    pend = 1'b0; done_f = 1'b0; pid = '0; pdat = '0;
    for (int k = 0; k <= max_k && !done_f; k++) begin
      cyc();
      sample_tick    = (k == 0);
      bus.req_ready  = !(k >= stall_lo && k <= stall_hi);
      bus.data_ready = pend;
      bus.r_id_in    = pid;
      bus.from_ram   = pdat;
      pend = 1'b0;
      @(negedge clk);
      if (bus.playback_req) begin
        if (n_req < 16) begin
          r_addr[n_req] = bus.playback_addr;
          r_id[n_req]   = bus.r_id_out;
          r_cyc[n_req]  = k;
        end
        n_req++;
        if (!hold_ret) begin
          pend = 1'b1;
          pid  = bus.r_id_out;
          pdat = bus.playback_addr[DW-1:0] ^ 16'hA5A5;
        end
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = k;
        if (!hold_ret) done_f = 1'b1;
      end
    end
    cyc();
    sample_tick = 1'b0; bus.data_ready = 1'b0; bus.req_ready = 1'b1;
    if (!hold_ret) begin
      total++;
      if (fd_cnt == 0) begin bad++; $display("FAIL frame_timeout: frame_done count=%0d required>=1", fd_cnt); end
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    total++; if (bus.playback_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", bus.playback_req); end
    total++; if (bus.playback_addr !== '0) begin bad++; $display("FAIL rst_addr: got %0h want 0", bus.playback_addr); end
    total++; if (voice_active !== '0) begin bad++; $display("FAIL rst_active: got %b want 0", voice_active); end
    total++; if (voice_sample !== '0) begin bad++; $display("FAIL rst_sample: got %0h want 0", voice_sample); end
    total++; if ({frame_done, overrun} !== 2'b00) begin bad++; $display("FAIL rst_flags: got %b want 00", {frame_done, overrun}); end
    cyc();
    reset = 1'b1;
  endtask

  task automatic test_loop_voice0();
    logic [AW-1:0] exp_a [4];
    exp_a[0] = 27'd100; exp_a[1] = 27'd101; exp_a[2] = 27'd102; exp_a[3] = 27'd100;
    set_voice(0, 27'd100, 27'd102);
    loop_en = 8'b0101_0011;
    voice_start = 8'h01; cyc(); voice_start = '0;
    for (int i = 0; i < 4; i++) begin
      do_frame(1'b0, 40, 99, 0);
      @(negedge clk);
      total++; if (n_req != 1) begin bad++; $display("FAIL loop_nreq[%0d]: got %0d want 1", i, n_req); end
      total++; if (r_addr[0] !== exp_a[i]) begin bad++; $display("FAIL loop_addr[%0d]: got %0d want %0d", i, r_addr[0], exp_a[i]); end
      total++; if (r_id[0] !== 3'd0) begin bad++; $display("FAIL loop_id[%0d]: got %0d want 0", i, r_id[0]); end
      total++; if (r_cyc[0] != 1) begin bad++; $display("FAIL loop_lat[%0d]: got %0d want 1", i, r_cyc[0]); end
      total++; if (fd_cyc != 9) begin bad++; $display("FAIL loop_fd[%0d]: got %0d want 9", i, fd_cyc); end
      total++; if (voice_sample[DW-1:0] !== (exp_a[i][DW-1:0] ^ 16'hA5A5)) begin
        bad++; $display("FAIL loop_sample[%0d]: got %0h want %0h", i, voice_sample[DW-1:0], exp_a[i][DW-1:0] ^ 16'hA5A5);
      end
    end
  endtask

  task automatic test_oneshot();
    set_voice(3, 27'd5, 27'd5);
    set_voice(5, 27'd50, 27'd60);
    voice_start = 8'b0010_1000; voice_stop = 8'b0010_0001; cyc();
    voice_start = '0; voice_stop = '0;
    do_frame(1'b0, 40, 99, 0);
    @(negedge clk);
    total++; if (n_req != 1) begin bad++; $display("FAIL shot_nreq: got %0d want 1", n_req); end
    total++; if (r_addr[0] !== 27'd5) begin bad++; $display("FAIL shot_addr: got %0d want 5", r_addr[0]); end
    total++; if (r_id[0] !== 3'd3) begin bad++; $display("FAIL shot_id: got %0d want 3", r_id[0]); end
    total++; if (r_cyc[0] != 4) begin bad++; $display("FAIL shot_cyc: got %0d want 4", r_cyc[0]); end
    total++; if (voice_active !== 8'h00) begin bad++; $display("FAIL shot_active: got %b want 0", voice_active); end
    do_frame(1'b0, 40, 99, 0);
    total++; if (n_req != 0) begin bad++; $display("FAIL shot_tick2: got %0d reqs want 0", n_req); end
    total++; if (fd_cyc != 9) begin bad++; $display("FAIL idle_frame_fd: got %0d want 9", fd_cyc); end
  endtask

  task automatic test_stall();
    logic [IDW-1:0] eid [3];
    logic [AW-1:0]  ead [3];
    int             ecy [3];
    eid[0] = 3'd1; eid[1] = 3'd4; eid[2] = 3'd6;
    ead[0] = 27'd200; ead[1] = 27'd400; ead[2] = 27'd600;
    ecy[0] = 2; ecy[1] = 8; ecy[2] = 10;
    set_voice(1, 27'd200, 27'd210);
    set_voice(4, 27'd400, 27'd410);
    set_voice(6, 27'd600, 27'd610);
    voice_start = 8'b0101_0010; cyc(); voice_start = '0;
    do_frame(1'b1, 14, 5, 7);
    @(negedge clk);
    total++; if (n_req != 3) begin bad++; $display("FAIL stall_nreq: got %0d want 3", n_req); end
    for (int i = 0; i < 3; i++) begin
      total++; if (r_id[i] !== eid[i]) begin bad++; $display("FAIL stall_id[%0d]: got %0d want %0d", i, r_id[i], eid[i]); end
      total++; if (r_addr[i] !== ead[i]) begin bad++; $display("FAIL stall_addr[%0d]: got %0d want %0d", i, r_addr[i], ead[i]); end
      total++; if (r_cyc[i] != ecy[i]) begin bad++; $display("FAIL stall_cyc[%0d]: got %0d want %0d", i, r_cyc[i], ecy[i]); end
    end
    total++; if (voice_active !== 8'b0101_0010) begin bad++; $display("FAIL stall_active: got %b want 01010010", voice_active); end
    total++; if (fd_cnt != 0) begin bad++; $display("FAIL stall_fd: got %0d want 0", fd_cnt); end
  endtask

  task automatic test_out_of_order();
    logic [IDW-1:0] ids [3];
    logic [DW-1:0]  vals [3];
    logic           exp_fd;
    ids[0] = 3'd6; ids[1] = 3'd1; ids[2] = 3'd4;
    vals[0] = 16'h6666; vals[1] = 16'h1111; vals[2] = 16'h4444;
    cyc(); bus.data_ready = 1'b1; bus.r_id_in = 3'd2; bus.from_ram = 16'hBAD0;
    cyc(); bus.data_ready = 1'b0;
    @(negedge clk);
    total++; if (voice_sample[2*DW +: DW] !== 16'h0000) begin bad++; $display("FAIL drop_sample: got %0h want 0", voice_sample[2*DW +: DW]); end
    for (int i = 0; i < 3; i++) begin
      cyc(); bus.data_ready = 1'b1; bus.r_id_in = ids[i]; bus.from_ram = vals[i];
      @(negedge clk);
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL ooo_fd_during[%0d]: got %b want 0", i, frame_done); end
      cyc(); bus.data_ready = 1'b0;
      @(negedge clk);
      exp_fd = (i == 2);
      total++; if (frame_done !== exp_fd) begin bad++; $display("FAIL ooo_fd_after[%0d]: got %b want %b", i, frame_done, exp_fd); end
      total++; if (voice_sample[ids[i]*DW +: DW] !== vals[i]) begin
        bad++; $display("FAIL ooo_sample[%0d]: got %0h want %0h", ids[i], voice_sample[ids[i]*DW +: DW], vals[i]);
      end
    end
    cyc();
    @(negedge clk);
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL ooo_fd_once: got %b want 0", frame_done); end
  endtask

  task automatic test_overrun();
    int nx;
    logic [IDW-1:0] ids [3];
    ids[0] = 3'd1; ids[1] = 3'd4; ids[2] = 3'd6;
    @(negedge clk);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_init: got %b want 0", overrun); end
    do_frame(1'b1, 12, 99, 0);
    total++; if (n_req != 3) begin bad++; $display("FAIL ovr_nreq: got %0d want 3", n_req); end
    total++; if ({r_addr[0], r_addr[1], r_addr[2]} !== {27'd201, 27'd401, 27'd601}) begin
      bad++; $display("FAIL ovr_addrs: got %0d,%0d,%0d want 201,401,601", r_addr[0], r_addr[1], r_addr[2]);
    end
    cyc(); sample_tick = 1'b1;
    cyc(); sample_tick = 1'b0;
    @(negedge clk);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", overrun); end
    nx = 0;
    repeat (8) begin
      cyc();
      @(negedge clk);
      if (bus.playback_req) nx++;
    end
    total++; if (nx != 0) begin bad++; $display("FAIL ovr_extra_req: got %0d want 0", nx); end
    for (int i = 0; i < 3; i++) begin
      cyc(); bus.data_ready = 1'b1; bus.r_id_in = ids[i]; bus.from_ram = 16'h0100 + 16'(i);
    end
    cyc(); bus.data_ready = 1'b0;
    @(negedge clk);
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL ovr_fd: got %b want 1", frame_done); end
    cyc();
    @(negedge clk);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_reset_mid_issue();
    cyc(); sample_tick = 1'b1;
    cyc(); sample_tick = 1'b0;
    cyc();
    @(negedge clk);
    total++; if ({bus.playback_req, bus.r_id_out} !== {1'b1, 3'd1}) begin
      bad++; $display("FAIL mid_req: got req=%b id=%0d want req=1 id=1", bus.playback_req, bus.r_id_out);
    end
    #2 reset = 1'b0;
    #1;
    total++; if ({bus.playback_req, bus.playback_addr, bus.r_id_out} !== '0) begin
      bad++; $display("FAIL mid_rst_bus: got req=%b addr=%0d id=%0d want 0", bus.playback_req, bus.playback_addr, bus.r_id_out);
    end
    total++; if (voice_active !== '0) begin bad++; $display("FAIL mid_rst_active: got %b want 0", voice_active); end
    total++; if (voice_sample !== '0) begin bad++; $display("FAIL mid_rst_sample: got %0h want 0", voice_sample); end
    total++; if ({frame_done, overrun} !== 2'b00) begin bad++; $display("FAIL mid_rst_flags: got %b want 00", {frame_done, overrun}); end
    cyc(); cyc();
    reset = 1'b1;
    do_frame(1'b0, 40, 99, 0);
    total++; if (n_req != 0) begin bad++; $display("FAIL post_rst_nreq: got %0d want 0", n_req); end
    total++; if (fd_cyc != 9) begin bad++; $display("FAIL post_rst_fd: got %0d want 9", fd_cyc); end
  endtask

  initial begin
    bus.req_ready  = 1'b1;
    bus.data_ready = 1'b0;
    bus.from_ram   = '0;
    bus.r_id_in    = '0;
    test_reset();
    test_loop_voice0();
    test_oneshot();
    test_stall();
    test_out_of_order();
    test_overrun();
    test_reset_mid_issue();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
